// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray read pointer, registered empty
// flag and occupancy, and a single registered output stage with valid/ready.
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = 8,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  rclk,
    input  logic                  r_rst,
    input  logic [PTR_WIDTH-1:0]  rq2_wptr,
    input  logic [FIFO_WIDTH-1:0] rdata,
    input  logic                  out_ready,
    output logic [PTR_WIDTH-2:0]  raddr,
    output logic [PTR_WIDTH-1:0]  rptr,
    output logic                  rempty,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [PTR_WIDTH-1:0]  rcount
);

    logic [PTR_WIDTH-1:0]  rbin_q, rbin_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rgray_d;
    logic                  rempty_q, rempty_d;
    logic [FIFO_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [PTR_WIDTH-1:0]  rcount_q, rcount_d;
    logic [PTR_WIDTH-1:0]  wbin;
    logic                  pop;

    gray2bin #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // A word leaves memory only when the output register is free or being drained.
    assign pop = !rempty_q && (!out_valid_q || out_ready);

    always_comb begin
        rbin_d      = rbin_q + {{(PTR_WIDTH-1){1'b0}}, pop};
        rgray_d     = (rbin_d >> 1) ^ rbin_d;
        // Compare against the post-pop pointer so a same-cycle pop and write
        // pointer update neither fakes data nor hides a word.
        rempty_d    = (rgray_d == rq2_wptr);
        rcount_d    = wbin - rbin_d;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_data_d  = rdata;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rbin_q      <= '0;
            rptr_q      <= '0;
            rempty_q    <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rcount_q    <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_q      <= rgray_d;
            rempty_q    <= rempty_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rcount_q    <= rcount_d;
        end
    end

    assign raddr     = rbin_q[PTR_WIDTH-2:0];
    assign rptr      = rptr_q;
    assign rempty    = rempty_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rcount    = rcount_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a scoreboard of expected delivered words.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       r_rst;
    logic [3:0] rq2_wptr;
    logic [7:0] rdata;
    logic       out_ready;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] rcount;

    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 rclk = ~rclk;

    assign rdata = mem[raddr];

    fifo_rd_ctrl #(
        .FIFO_WIDTH (8),
        .PTR_WIDTH  (4)
    ) dut (
        .rclk      (rclk),
        .r_rst     (r_rst),
        .rq2_wptr  (rq2_wptr),
        .rdata     (rdata),
        .out_ready (out_ready),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .out_data  (out_data),
        .out_valid (out_valid),
        .rcount    (rcount)
    );

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge rclk);
        #2;
        r_rst    = 1'b1;
        rq2_wptr = 4'b0000;
        exp_q.delete();
        tick(1);
        r_rst = 1'b0;
    endtask

    task automatic preload(logic [7:0] base);
        for (int i = 0; i < 8; i++) mem[i] = base + 8'(i);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge rclk) begin
        if (!r_rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL delivered_word: got 0x%0h expected 0x%0h", out_data, e);
                end
            end
        end
    end

    initial begin
        r_rst     = 1'b1;
        rq2_wptr  = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #2;
        chk("reset_rempty", int'(rempty), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_rptr", int'(rptr), 0);
        chk("reset_rcount", int'(rcount), 0);
        tick(2);
        chk("idle_rempty", int'(rempty), 1);
        r_rst = 1'b0;
        tick(2);
        chk("idle_after_reset_rempty", int'(rempty), 1);

        // Single word
        pulse_reset();
        mem[0]    = 8'hA5;
        out_ready = 1'b1;
        rq2_wptr  = 4'b0001;
        exp_q.push_back(8'hA5);
        tick(1);
        chk("single_rempty_low", int'(rempty), 0);
        chk("single_not_yet_valid", int'(out_valid), 0);
        tick(1);
        chk("single_out_valid", int'(out_valid), 1);
        chk("single_out_data", int'(out_data), 'hA5);
        chk("single_rempty_high", int'(rempty), 1);
        chk("single_rptr", int'(rptr), 'b0001);
        tick(1);
        chk("single_drained", int'(out_valid), 0);

        // Full FIFO streamed back-to-back
        pulse_reset();
        preload(8'h10);
        out_ready = 1'b1;
        rq2_wptr  = 4'b1100;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        tick(1);
        chk("full_rcount", int'(rcount), 8);
        chk("full_rempty", int'(rempty), 0);
        chk("full_not_yet_valid", int'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("stream_valid", int'(out_valid), 1);
            chk("stream_data", int'(out_data), 'h10 + i);
        end
        chk("stream_rptr", int'(rptr), 'b1100);
        chk("stream_rempty", int'(rempty), 1);
        chk("stream_raddr", int'(raddr), 0);
        chk("stream_rcount", int'(rcount), 0);
        tick(1);
        chk("stream_drained", int'(out_valid), 0);

        // Backpressure then release
        pulse_reset();
        preload(8'h10);
        out_ready = 1'b0;
        rq2_wptr  = 4'b1100;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        tick(1);
        chk("bp_rcount_initial", int'(rcount), 8);
        tick(1);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), 'h10);
        chk("bp_rcount", int'(rcount), 7);
        chk("bp_raddr", int'(raddr), 1);
        tick(2);
        chk("bp_hold_data", int'(out_data), 'h10);
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_raddr", int'(raddr), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("release_valid", int'(out_valid), 1);
            chk("release_data", int'(out_data), 'h11 + i);
        end
        tick(1);
        out_ready = 1'b0;
        chk("pre_reset_valid", int'(out_valid), 1);
        chk("pre_reset_rcount", int'(rcount), 3);
        chk("pre_reset_data", int'(out_data), 'h14);

        // Asynchronous reset mid-transfer
        #2;
        r_rst    = 1'b1;
        rq2_wptr = 4'b0000;
        exp_q.delete();
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data", int'(out_data), 0);
        chk("async_rst_rempty", int'(rempty), 1);
        chk("async_rst_rptr", int'(rptr), 0);
        chk("async_rst_rcount", int'(rcount), 0);
        chk("async_rst_raddr", int'(raddr), 0);
        @(posedge rclk);
        #1;
        r_rst     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("post_rst_no_word", int'(out_valid), 0);
            chk("post_rst_empty", int'(rempty), 1);
        end

        // Pointer wrap with write pointer moving during pops
        pulse_reset();
        preload(8'h20);
        out_ready = 1'b1;
        rq2_wptr  = 4'b0100;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h20 + 8'(i));
        tick(1);
        chk("wrap_pre_rempty", int'(rempty), 0);
        tick(7);
        chk("wrap_pre_rptr", int'(rptr), 'b0100);
        chk("wrap_pre_rempty_high", int'(rempty), 1);
        chk("wrap_pre_raddr", int'(raddr), 7);
        mem[7] = 8'hC7;
        mem[0] = 8'hC0;
        mem[1] = 8'hC1;
        exp_q.push_back(8'hC7);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        rq2_wptr = 4'b1100;
        tick(1);
        chk("wrap_rptr0", int'(rptr), 'b0100);
        chk("wrap_rempty0", int'(rempty), 0);
        rq2_wptr = 4'b1101;
        tick(1);
        chk("wrap_rptr1", int'(rptr), 'b1100);
        chk("wrap_data1", int'(out_data), 'hC7);
        chk("wrap_rempty1", int'(rempty), 0);
        rq2_wptr = 4'b1111;
        tick(1);
        chk("wrap_rptr2", int'(rptr), 'b1101);
        chk("wrap_data2", int'(out_data), 'hC0);
        tick(1);
        chk("wrap_rptr3", int'(rptr), 'b1111);
        chk("wrap_data3", int'(out_data), 'hC1);
        chk("wrap_rempty3", int'(rempty), 1);
        chk("wrap_raddr3", int'(raddr), 2);
        chk("wrap_rcount3", int'(rcount), 0);
        tick(2);
        chk("wrap_drained", int'(out_valid), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
